keys_debounce_multi: RTL
========================

Name: keys_debounce_multi

Overview:
- Multi-channel push-button conditioner for board-level key inputs. Each key is synchronised, then debounced by multi-sample stability checking on a shared sample tick.
- Per channel it produces a clean level and press/release pulses, plus long-press and auto-repeat pulses.
- Sits between raw FPGA key pins and user control logic, for menus and parameter stepping.

Parameters:
- W, 1, number of independent key channels.
- TICK_DIV, 1000000, clocks per sample tick (10 ms at 100 MHz); must be >= 2.
- STABLE_N, 3, consecutive differing ticks required to accept a new level; must be >= 1.
- ACTIVE_LOW, 0: when 1, keyin is inverted before processing so that pressed = 1 internally.
- LONG_TICKS, 100, ticks a key must be held after its press pulse before keylong fires; must be >= 1.
- REPEAT_TICKS, 20, ticks between keyrepeat pulses after keylong; 0 disables repeat.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- keyin  in  W  raw asynchronous key inputs.
- keylevel  out  W  debounced level, 1 = pressed.
- keypress  out  W  1-cycle pulse on accepted 0->1.
- keyrelease  out  W  1-cycle pulse on accepted 1->0.
- keylong  out  W  1-cycle pulse when the hold reaches LONG_TICKS.
- keyrepeat  out  W  1-cycle pulse every REPEAT_TICKS while in long hold.
- tick  out  1  1-cycle sample strobe, shared by all channels.

Behaviour:
- Reset (rst=1 at a clk edge) clears the following to 0:
  - the tick counter;
  - the 2-FF synchroniser (post-inversion value);
  - stability counters and hold counters;
  - all outputs, with every channel state set to IDLE.
- Input path: apply the ACTIVE_LOW inversion, then a 2-stage synchroniser per bit. Call the result s[i].
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 during the cycle in which the counter equals TICK_DIV-1.
  - The counter width is clog2(TICK_DIV).
- Debounce, per channel, evaluated only on tick cycles:
  - if s[i] != keylevel[i], stab[i] increments;
  - if s[i] == keylevel[i], stab[i] clears to 0;
  - when the incremented value equals STABLE_N, keylevel[i] toggles at that clock edge and stab[i] clears.
  - A bounce shorter than STABLE_N consecutive ticks never changes keylevel.
- Edge pulses:
  - keypress[i] = keylevel[i] & ~lvl_d[i] and keyrelease[i] = ~keylevel[i] & lvl_d[i], where lvl_d is keylevel delayed by one clk.
  - Both pulses are registered and coincide with the first cycle of the new level.
- Latency from a clean raw edge to keylevel: between 2 + (STABLE_N-1)*TICK_DIV + 1 and 2 + STABLE_N*TICK_DIV clocks.
- Hold FSM per channel, with states IDLE, HELD and LONG, and a hold counter hc of width clog2(max(LONG_TICKS, REPEAT_TICKS)+1):
  - IDLE: on the cycle keypress[i]=1, go to HELD with hc=0.
  - HELD: each tick with keylevel=1, hc increments. When hc+1 == LONG_TICKS, keylong[i]=1 for the following clk cycle, state goes to LONG and hc=0.
  - LONG: if REPEAT_TICKS>0, each tick hc increments. When hc+1 == REPEAT_TICKS, keyrepeat[i]=1 for the following cycle and hc=0.
  - Any state: keylevel[i]=0 moves the channel to IDLE with hc=0, without exception.
- Simultaneous events:
  - If the debounce release and a long/repeat condition fall on the same tick, the release wins: keyrelease fires and keylong/keyrepeat do not.
  - Channels are fully independent, so any combination of channels may pulse in the same cycle.
- Pulse widths: keypress, keyrelease, keylong, keyrepeat and tick are exactly 1 cycle and never stretched.
- A channel never asserts keyrepeat before its keylong.
- Reset mid-operation: all state is cleared immediately. A key still held after reset deasserts produces a fresh keypress once debounced, i.e. on the STABLE_N-th tick after s[i] becomes 1.
- Arithmetic: all counters are unsigned and saturation is never needed, because each counter is cleared at its terminal value.

Test Plan:
Bench parameters: W=2, TICK_DIV=4, STABLE_N=3, LONG_TICKS=5, REPEAT_TICKS=2, ACTIVE_LOW=0.
1. Reset for 3 cycles, keyin=00 -> all outputs 0; tick pulses at clocks 4, 8, 12 after reset release; keylevel remains 00.
2. keyin[0] goes high for 2 ticks, low for 1 tick, then high steadily -> no keypress during the bounce; keylevel[0] rises on the 3rd consecutive high tick, with keypress[0]=1 for exactly 1 cycle.
3. Hold keyin[0] high -> keylong[0] pulses once, 5 ticks (20 clocks) after the keypress tick; keyrepeat[0] then pulses every 2 ticks (8 clocks), 4 times over 8 further ticks.
4. Press keyin[1] and release it after 3 accepted-high ticks -> keyrelease[1] fires after 3 low ticks; keylong[1] never fires. Then release ch0 while it is in LONG -> one keyrelease[0], and no keyrepeat afterwards.
5. Drive keyin=11 on the same cycle -> keypress=11 in the same cycle. Also rebuild with ACTIVE_LOW=1 and hold keyin=00 -> keylevel becomes 11 after 3 ticks.
6. Assert rst while ch0 is in LONG with keyin[0] held -> outputs clear next cycle; after rst deasserts, keypress[0] reappears on the 3rd tick; keylong does not fire until 5 ticks after that.

Source files
------------

// File: rtl/keys_debounce_multi.sv
// keys_debounce_multi
//   Multi-channel push-button conditioner. Every raw key is optionally
//   inverted (so that pressed = 1 internally) and passed through a 2-FF
//   synchroniser. It is then debounced by counting consecutive sample ticks
//   on which it differs from the accepted level. A per-channel hold FSM turns
//   a sustained press into one long-press pulse followed by auto-repeat pulses.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   keyin      in   [W]  raw asynchronous key inputs
//   keylevel   out  [W]  debounced level, 1 = pressed
//   keypress   out  [W]  1-cycle pulse on accepted 0->1
//   keyrelease out  [W]  1-cycle pulse on accepted 1->0
//   keylong    out  [W]  1-cycle pulse when a hold reaches LONG_TICKS
//   keyrepeat  out  [W]  1-cycle pulse every REPEAT_TICKS while in long hold
//   tick       out       1-cycle sample strobe shared by all channels
//   dbg_state  out  [2W] hold FSM state per channel (2 bits each, channel i
//                        at [2i+1:2i]); observation only
//
// There is no valid/ready handshake here: every output is a level or a
// single-cycle strobe that the consumer must sample on the cycle it is high.

module keys_debounce_multi #(
  parameter int W            = 1,
  parameter int TICK_DIV     = 1000000,
  parameter int STABLE_N     = 3,
  parameter int ACTIVE_LOW   = 0,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   keyin,
  output logic [W-1:0]   keylevel,
  output logic [W-1:0]   keypress,
  output logic [W-1:0]   keyrelease,
  output logic [W-1:0]   keylong,
  output logic [W-1:0]   keyrepeat,
  output logic           tick,
  output logic [2*W-1:0] dbg_state
);

  localparam int CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW   = $clog2(STABLE_N + 1);
  localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW   = $clog2(HMAX + 1);

  // Terminal values: each counter is compared against "target - 1" so that
  // "incremented value == target" is a single equality on the current value.
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_N - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_e;

  // ---------------------------------------------------------------------------
  // Shared sample tick
  // ---------------------------------------------------------------------------
  logic [CW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (tcnt == TICK_LAST) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + CW'(1);
    end
  end

  assign tick = (tcnt == TICK_LAST);

  // ---------------------------------------------------------------------------
  // Polarity normalisation and 2-FF synchroniser
  // ---------------------------------------------------------------------------
  logic [W-1:0] kin;
  logic [W-1:0] sync1;
  logic [W-1:0] s;

  assign kin = (ACTIVE_LOW != 0) ? ~keyin : keyin;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= kin;
      s     <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: accept a new level after STABLE_N consecutive differing ticks
  // ---------------------------------------------------------------------------
  logic [SW-1:0] stab [W];
  logic [W-1:0]  lvl_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < W; i++) begin
        stab[i] <= '0;
      end
      keylevel <= '0;
      lvl_d    <= '0;
    end else begin
      lvl_d <= keylevel;
      if (tick) begin
        for (int i = 0; i < W; i++) begin
          if (s[i] != keylevel[i]) begin
            if (stab[i] == STAB_LAST) begin
              keylevel[i] <= ~keylevel[i];
              stab[i]     <= '0;
            end else begin
              stab[i] <= stab[i] + SW'(1);
            end
          end else begin
            stab[i] <= '0;
          end
        end
      end
    end
  end

  // Both edge pulses come from registers only, so they are glitch-free and
  // line up with the first cycle of the new level.
  assign keypress   = keylevel & ~lvl_d;
  assign keyrelease = ~keylevel & lvl_d;

  // A release is being accepted on this very tick. Used to let a release
  // suppress a long/repeat pulse that would fall on the same tick.
  logic [W-1:0] rel_now;

  always_comb begin
    rel_now = '0;
    for (int i = 0; i < W; i++) begin
      rel_now[i] = tick & keylevel[i] & ~s[i] & (stab[i] == STAB_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // Hold FSM: IDLE -> HELD (count to LONG_TICKS) -> LONG (repeat period)
  // ---------------------------------------------------------------------------
  hold_e         st_q [W];
  hold_e         st_d [W];
  logic [HW-1:0] hc_q [W];
  logic [HW-1:0] hc_d [W];
  logic [W-1:0]  long_d;
  logic [W-1:0]  rep_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < W; i++) begin
        st_q[i] <= IDLE;
        hc_q[i] <= '0;
      end
      keylong   <= '0;
      keyrepeat <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        st_q[i] <= st_d[i];
        hc_q[i] <= hc_d[i];
      end
      keylong   <= long_d;
      keyrepeat <= rep_d;
    end
  end

  always_comb begin
    long_d = '0;
    rep_d  = '0;
    for (int i = 0; i < W; i++) begin
      st_d[i] = st_q[i];
      hc_d[i] = hc_q[i];
      case (st_q[i])
        IDLE: begin
          if (keypress[i]) begin
            st_d[i] = HELD;
            hc_d[i] = '0;
          end
        end
        HELD: begin
          if (!keylevel[i] || rel_now[i]) begin
            st_d[i] = IDLE;
            hc_d[i] = '0;
          end else if (tick) begin
            if (hc_q[i] == LONG_LAST) begin
              long_d[i] = 1'b1;
              st_d[i]   = LONG;
              hc_d[i]   = '0;
            end else begin
              hc_d[i] = hc_q[i] + HW'(1);
            end
          end
        end
        LONG: begin
          if (!keylevel[i] || rel_now[i]) begin
            st_d[i] = IDLE;
            hc_d[i] = '0;
          end else if ((REPEAT_TICKS > 0) && tick) begin
            if (hc_q[i] == REP_LAST) begin
              rep_d[i] = 1'b1;
              hc_d[i]  = '0;
            end else begin
              hc_d[i] = hc_q[i] + HW'(1);
            end
          end
        end
        default: begin
          st_d[i] = IDLE;
          hc_d[i] = '0;
        end
      endcase
    end
  end

  always_comb begin
    dbg_state = '0;
    for (int i = 0; i < W; i++) begin
      dbg_state[2*i +: 2] = st_q[i];
    end
  end

endmodule
